mem_access_unit: RTL and testbench

//  - Initiator side of the CPU data-memory interface. Accepts load/store requests from the pipeline over a

---
 rtl/cpu_mem_pkg.sv | 32 +++
 rtl/mem_access_unit_if.sv | 50 +++++
 rtl/mau_lat_counter.sv | 38 +++
 rtl/mem_access_unit.sv | 178 +++++++++++++++++
 tb/tb_mem_access_unit.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_mem_pkg.sv
// ============================================================================
// Module : cpu_mem_pkg
// Brief  : Shared CPU data-memory definitions: bus widths, the memory access
//          unit state encoding and a read-latency range helper.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package cpu_mem_pkg;

    // Bus widths shared by datamemory, the pipeline and the access unit
    localparam int CPU_ADDR_W = 16;
    localparam int CPU_DATA_W = 16;

    // Width of the read-latency counter; bounds the legal RD_LAT range
    localparam int MAU_CNT_W  = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RESP = 2'd3
    } mau_state_t;

    // True when a read latency fits the counter without wrapping
    function automatic logic lat_in_range(input int lat);
        return (lat >= 1) && (lat <= (1 << MAU_CNT_W) - 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_access_unit_if.sv
// ============================================================================
// Module : mem_access_unit_if
// Brief  : Pipeline request/response handshake plus datamemory strobe bus.
//          slave  = the access unit; master = pipeline + datamemory side.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface mem_access_unit_if
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_W = CPU_ADDR_W,
    parameter int DATA_W = CPU_DATA_W
);

    // Pipeline request channel
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;

    // Pipeline response channel
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_fault;

    // datamemory port
    logic              rEnable;
    logic              wEnable;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] wData;
    logic [DATA_W-1:0] rData;

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, resp_ready, rData,
        output req_ready, resp_valid, resp_rdata, resp_fault,
               rEnable, wEnable, address, wData
    );

    modport master (
        output req_valid, req_write, req_addr, req_wdata, resp_ready, rData,
        input  req_ready, resp_valid, resp_rdata, resp_fault,
               rEnable, wEnable, address, wData
    );

endinterface

`default_nettype wire

// File: rtl/mau_lat_counter.sv
// ============================================================================
// Module : mau_lat_counter
// Brief  : 3-bit load/count/done counter timing the datamemory read latency.
//          Load clears to zero; counting saturates at LAST so it never wraps.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mau_lat_counter
    import cpu_mem_pkg::*;
#(
    parameter logic [MAU_CNT_W-1:0] LAST = '0
) (
    input  logic clk,
    input  logic rst,      // asynchronous, active-low
    input  logic load,
    input  logic en,
    output logic done
);

    logic [MAU_CNT_W-1:0] r_cnt;

    // Clear on load, otherwise advance while enabled until LAST is reached
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= '0;
        end else if (en && (r_cnt != LAST)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign done = (r_cnt == LAST);

endmodule

`default_nettype wire

// File: rtl/mem_access_unit.sv
// ============================================================================
// Module : mem_access_unit
// Brief  : Initiator side of the CPU data-memory interface. Accepts one
//          load/store at a time over valid/ready, drives datamemory strobes,
//          captures read data and returns it. All outputs are registered.
//          Optional macro MAU_ALIGN_CHECK_EN: misaligned accesses (addr[0]=1)
//          are rejected with resp_fault instead of being word-aligned.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_access_unit
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_W = CPU_ADDR_W,
    parameter int DATA_W = CPU_DATA_W,
    parameter int RD_LAT = 1
) (
    input  logic clk,
    input  logic rst,      // asynchronous, active-low
    mem_access_unit_if.slave bus
);

    // The latency counter holds RD_LAT-1 at most; larger values cannot be timed
    generate
        if (!lat_in_range(RD_LAT)) begin : g_bad_rd_lat
            $error("mem_access_unit: RD_LAT=%0d outside 1..7", RD_LAT);
        end
    endgenerate

    localparam logic [MAU_CNT_W-1:0] c_LAST_CNT = MAU_CNT_W'(RD_LAT - 1);

    mau_state_t        r_state;
    mau_state_t        w_state_next;

    logic              r_req_ready,  w_req_ready_next;
    logic              r_resp_valid, w_resp_valid_next;
    logic [DATA_W-1:0] r_resp_rdata, w_resp_rdata_next;
    logic              r_resp_fault, w_resp_fault_next;
    logic              r_ren,        w_ren_next;
    logic              r_wen,        w_wen_next;
    logic [ADDR_W-1:0] r_addr,       w_addr_next;
    logic [DATA_W-1:0] r_wdata,      w_wdata_next;

    logic              w_accept;
    logic              w_misalign;
    logic [ADDR_W-1:0] w_req_addr;
    logic              w_cnt_load;
    logic              w_lat_done;

    assign w_accept = bus.req_valid && r_req_ready && (r_state == IDLE);

`ifdef MAU_ALIGN_CHECK_EN
    // Odd byte addresses are rejected; the raw address is still presented
    assign w_misalign = bus.req_addr[0];
    assign w_req_addr = bus.req_addr;
`else
    // Bit 0 is dropped so every access is word-aligned; nothing is rejected
    logic w_unused_addr0;
    assign w_unused_addr0 = bus.req_addr[0];
    assign w_misalign     = 1'b0;
    assign w_req_addr     = {bus.req_addr[ADDR_W-1:1], 1'b0};
`endif

    mau_lat_counter #(
        .LAST (c_LAST_CNT)
    ) u_lat_counter (
        .clk  (clk),
        .rst  (rst),
        .load (w_cnt_load),
        .en   (r_state == RD),
        .done (w_lat_done)
    );

    // Next state and next registered output values
    always_comb begin
        w_state_next      = r_state;
        w_resp_valid_next = r_resp_valid;
        w_resp_rdata_next = r_resp_rdata;
        w_resp_fault_next = r_resp_fault;
        w_ren_next        = 1'b0;
        w_wen_next        = 1'b0;
        w_addr_next       = r_addr;
        w_wdata_next      = r_wdata;
        w_cnt_load        = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_addr_next  = w_req_addr;
                    w_wdata_next = bus.req_wdata;
                    if (w_misalign) begin
                        // Rejected: straight to the response, no strobe
                        w_state_next      = RESP;
                        w_resp_valid_next = 1'b1;
                        w_resp_rdata_next = '0;
                        w_resp_fault_next = 1'b1;
                    end else if (bus.req_write) begin
                        w_state_next = WR;
                        w_wen_next   = 1'b1;
                    end else begin
                        w_state_next = RD;
                        w_ren_next   = 1'b1;
                        w_cnt_load   = 1'b1;
                    end
                end
            end
            RD: begin
                if (w_lat_done) begin
                    // Last strobe cycle: rData is valid now
                    w_state_next      = RESP;
                    w_resp_valid_next = 1'b1;
                    w_resp_rdata_next = bus.rData;
                    w_resp_fault_next = 1'b0;
                end else begin
                    w_ren_next = 1'b1;
                end
            end
            WR: begin
                w_state_next      = RESP;
                w_resp_valid_next = 1'b1;
                w_resp_rdata_next = '0;
                w_resp_fault_next = 1'b0;
            end
            RESP: begin
                if (bus.resp_ready) begin
                    w_state_next      = IDLE;
                    w_resp_valid_next = 1'b0;
                    w_resp_rdata_next = '0;
                    w_resp_fault_next = 1'b0;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase

        // Ready only once settled in IDLE, so a retiring response never overlaps an accept
        w_req_ready_next = (w_state_next == IDLE);
    end

    // State and output registers; reset drops every strobe immediately
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_req_ready  <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_resp_fault <= 1'b0;
            r_ren        <= 1'b0;
            r_wen        <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
        end else begin
            r_state      <= w_state_next;
            r_req_ready  <= w_req_ready_next;
            r_resp_valid <= w_resp_valid_next;
            r_resp_rdata <= w_resp_rdata_next;
            r_resp_fault <= w_resp_fault_next;
            r_ren        <= w_ren_next;
            r_wen        <= w_wen_next;
            r_addr       <= w_addr_next;
            r_wdata      <= w_wdata_next;
        end
    end

    assign bus.req_ready  = r_req_ready;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_rdata = r_resp_rdata;
    assign bus.resp_fault = r_resp_fault;
    assign bus.rEnable    = r_ren;
    assign bus.wEnable    = r_wen;
    assign bus.address    = r_addr;
    assign bus.wData      = r_wdata;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
// ============================================================================
// Module : tb_mem_access_unit
// Brief  : Directed self-checking bench for mem_access_unit. One instance with
//          RD_LAT=3 runs the main sequence; instances with RD_LAT=1 and 7 run
//          a latency sweep. Expected values are hand-derived constants.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem_access_unit;

    localparam int MAIN_LAT = 3;

    logic clk;
    logic rst;

    int n_checks = 0;
    int n_pass   = 0;

    mem_access_unit_if #(.ADDR_W(16), .DATA_W(16)) bus_m ();
    mem_access_unit_if #(.ADDR_W(16), .DATA_W(16)) bus_1 ();
    mem_access_unit_if #(.ADDR_W(16), .DATA_W(16)) bus_7 ();

    mem_access_unit #(.ADDR_W(16), .DATA_W(16), .RD_LAT(MAIN_LAT)) u_dut_m (
        .clk (clk), .rst (rst), .bus (bus_m)
    );
    mem_access_unit #(.ADDR_W(16), .DATA_W(16), .RD_LAT(1)) u_dut_1 (
        .clk (clk), .rst (rst), .bus (bus_1)
    );
    mem_access_unit #(.ADDR_W(16), .DATA_W(16), .RD_LAT(7)) u_dut_7 (
        .clk (clk), .rst (rst), .bus (bus_7)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Small word memory behind the main instance
    logic [15:0] mem [0:15] = '{default: 16'h0000};
    always @(posedge clk) begin
        if (bus_m.wEnable) mem[bus_m.address[4:1]] <= bus_m.wData;
    end
    assign bus_m.rData = mem[bus_m.address[4:1]];

    // Strobe-cycle counters (cumulative; the bench uses deltas)
    int ren_m = 0;
    int wen_m = 0;
    int ren_1 = 0;
    int ren_7 = 0;
    always @(posedge clk) begin
        if (bus_m.rEnable) ren_m <= ren_m + 1;
        if (bus_m.wEnable) wen_m <= wen_m + 1;
        if (bus_1.rEnable) ren_1 <= ren_1 + 1;
        if (bus_7.rEnable) ren_7 <= ren_7 + 1;
    end

    // Sweep memories return a value that advances each strobe cycle, so the
    // captured word shows which strobe cycle was sampled
    assign bus_1.rData = 16'h5000 + 16'(ren_1);
    assign bus_7.rData = 16'h5000 + 16'(ren_7);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Present one request on the main bus; returns in cycle N+1
    task automatic issue(input logic wr, input logic [15:0] a, input logic [15:0] d);
        bus_m.req_valid = 1'b1;
        bus_m.req_write = wr;
        bus_m.req_addr  = a;
        bus_m.req_wdata = d;
        tick();
        bus_m.req_valid = 1'b0;
    endtask

    // Wait for resp_valid; k = cycles after the accept edge
    task automatic wait_resp(output int k);
        k = 1;
        while (!bus_m.resp_valid && k < 15) begin
            tick();
            k++;
        end
        check("resp_valid_timeout", 32'(bus_m.resp_valid), 32'd1);
    endtask

    task automatic retire();
        bus_m.resp_ready = 1'b1;
        tick();
        bus_m.resp_ready = 1'b0;
    endtask

    task automatic do_store(input logic [15:0] a, input logic [15:0] d);
        int k;
        issue(1'b1, a, d);
        wait_resp(k);
        retire();
    endtask

    initial begin
        int k, k1, k7, r0, w0;

        rst = 1'b1;
        bus_m.req_valid = 1'b0; bus_m.req_write = 1'b0; bus_m.req_addr = '0;
        bus_m.req_wdata = '0;   bus_m.resp_ready = 1'b0;
        bus_1.req_valid = 1'b0; bus_1.req_write = 1'b0; bus_1.req_addr = '0;
        bus_1.req_wdata = '0;   bus_1.resp_ready = 1'b0;
        bus_7.req_valid = 1'b0; bus_7.req_write = 1'b0; bus_7.req_addr = '0;
        bus_7.req_wdata = '0;   bus_7.resp_ready = 1'b0;
        #1 rst = 1'b0;
        #2;

        // Reset state: every output low, including req_ready
        check("rst_req_ready",  32'(bus_m.req_ready),  32'd0);
        check("rst_resp_valid", 32'(bus_m.resp_valid), 32'd0);
        check("rst_rEnable",    32'(bus_m.rEnable),    32'd0);
        check("rst_wEnable",    32'(bus_m.wEnable),    32'd0);
        check("rst_address",    32'(bus_m.address),    32'h0);
        check("rst_wData",      32'(bus_m.wData),      32'h0);

        @(negedge clk) rst = 1'b1;
        tick();
        check("idle_req_ready", 32'(bus_m.req_ready), 32'd1);

        // Store 16'haaaa @ 16'h0000
        w0 = wen_m;
        issue(1'b1, 16'h0000, 16'haaaa);
        check("st_wEnable",   32'(bus_m.wEnable),   32'd1);
        check("st_rEnable",   32'(bus_m.rEnable),   32'd0);
        check("st_req_ready", 32'(bus_m.req_ready), 32'd0);
        check("st_address",   32'(bus_m.address),   32'h0000);
        check("st_wData",     32'(bus_m.wData),     32'haaaa);
        wait_resp(k);
        check("st_latency",   32'(k),               32'd2);
        check("st_rdata",     32'(bus_m.resp_rdata), 32'h0);
        check("st_wen_cycles", 32'(wen_m - w0),     32'd1);
        retire();
        check("st_ret_req_ready",  32'(bus_m.req_ready),  32'd1);
        check("st_ret_resp_valid", 32'(bus_m.resp_valid), 32'd0);

        // Load back @ 16'h0000
        r0 = ren_m;
        issue(1'b0, 16'h0000, 16'h0000);
        check("ld_rEnable", 32'(bus_m.rEnable), 32'd1);
        wait_resp(k);
        check("ld_latency",    32'(k),                32'(MAIN_LAT + 1));
        check("ld_rdata",      32'(bus_m.resp_rdata), 32'haaaa);
        check("ld_ren_cycles", 32'(ren_m - r0),       32'(MAIN_LAT));
        check("ld_ren_low",    32'(bus_m.rEnable),    32'd0);
        retire();

        // Back-pressure: load 16'h1111 @ 16'h1010, hold resp_ready low 5 cycles
        do_store(16'h1010, 16'h1111);
        issue(1'b0, 16'h1010, 16'h0000);
        wait_resp(k);
        r0 = ren_m;
        w0 = wen_m;
        for (int i = 0; i < 5; i++) begin
            check("bp_resp_valid", 32'(bus_m.resp_valid), 32'd1);
            check("bp_rdata",      32'(bus_m.resp_rdata), 32'h1111);
            check("bp_req_ready",  32'(bus_m.req_ready),  32'd0);
            tick();
        end
        check("bp_no_rd_strobe", 32'(ren_m - r0), 32'd0);
        check("bp_no_wr_strobe", 32'(wen_m - w0), 32'd0);
        retire();

        // Requests presented while in RD are ignored
        w0 = wen_m;
        issue(1'b0, 16'h0002, 16'h0000);
        bus_m.req_valid = 1'b1;
        bus_m.req_write = 1'b1;
        bus_m.req_addr  = 16'h0100;
        bus_m.req_wdata = 16'hdead;
        for (int i = 0; i < MAIN_LAT; i++) begin
            check("ign_address",   32'(bus_m.address),   32'h0002);
            check("ign_req_ready", 32'(bus_m.req_ready), 32'd0);
            tick();
        end
        check("ign_resp_valid", 32'(bus_m.resp_valid), 32'd1);
        check("ign_rdata",      32'(bus_m.resp_rdata), 32'h0000);
        bus_m.req_valid = 1'b0;
        retire();
        check("ign_no_store",     32'(wen_m - w0),     32'd0);
        check("ign_address_hold", 32'(bus_m.address),  32'h0002);

        // Alignment: load @ 16'h0003
        do_store(16'h0002, 16'h2222);
        r0 = ren_m;
        w0 = wen_m;
        issue(1'b0, 16'h0003, 16'h0000);
`ifdef MAU_ALIGN_CHECK_EN
        check("al_no_rEnable", 32'(bus_m.rEnable), 32'd0);
        wait_resp(k);
        check("al_latency",    32'(k),                32'd1);
        check("al_fault",      32'(bus_m.resp_fault), 32'd1);
        check("al_rdata",      32'(bus_m.resp_rdata), 32'h0);
        check("al_no_rd",      32'(ren_m - r0),       32'd0);
        check("al_no_wr",      32'(wen_m - w0),       32'd0);
`else
        check("al_address",    32'(bus_m.address),    32'h0002);
        wait_resp(k);
        check("al_latency",    32'(k),                32'(MAIN_LAT + 1));
        check("al_fault",      32'(bus_m.resp_fault), 32'd0);
        check("al_rdata",      32'(bus_m.resp_rdata), 32'h2222);
        check("al_no_wr",      32'(wen_m - w0),       32'd0);
`endif
        retire();

        // Asynchronous reset in the middle of a read
        issue(1'b0, 16'h0000, 16'h0000);
        check("mr_rEnable_before", 32'(bus_m.rEnable), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("mr_rEnable",    32'(bus_m.rEnable),    32'd0);
        check("mr_resp_valid", 32'(bus_m.resp_valid), 32'd0);
        check("mr_req_ready",  32'(bus_m.req_ready),  32'd0);
        @(negedge clk) rst = 1'b1;
        tick();
        check("mr_idle_ready", 32'(bus_m.req_ready),  32'd1);
        check("mr_no_resume",  32'(bus_m.rEnable),    32'd0);
        tick();
        check("mr_no_resp",    32'(bus_m.resp_valid), 32'd0);

        // Latency sweep on the RD_LAT=1 and RD_LAT=7 instances
        bus_1.req_valid = 1'b1; bus_1.req_addr = 16'h0040;
        bus_7.req_valid = 1'b1; bus_7.req_addr = 16'h0040;
        tick();
        bus_1.req_valid = 1'b0;
        bus_7.req_valid = 1'b0;
        k1 = 0;
        k7 = 0;
        for (int c = 1; c <= 12; c++) begin
            if (bus_1.resp_valid && k1 == 0) k1 = c;
            if (bus_7.resp_valid && k7 == 0) k7 = c;
            if (k1 != 0 && k7 != 0) break;
            tick();
        end
        check("sw1_latency",    32'(k1),               32'd2);
        check("sw7_latency",    32'(k7),               32'd8);
        check("sw1_ren_cycles", 32'(ren_1),            32'd1);
        check("sw7_ren_cycles", 32'(ren_7),            32'd7);
        check("sw1_rdata",      32'(bus_1.resp_rdata), 32'h5000);
        check("sw7_rdata",      32'(bus_7.resp_rdata), 32'h5006);
        bus_1.resp_ready = 1'b1;
        bus_7.resp_ready = 1'b1;
        tick();
        bus_1.resp_ready = 1'b0;
        bus_7.resp_ready = 1'b0;
        check("sw7_retired", 32'(bus_7.resp_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Hard stop in case a wait never completes
    initial begin
        #200000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
